// File: rtl/bcd_seven_seg_scanner_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : bcd_seven_seg_scanner_pkg
// Brief   : Shared scan states and active-low segment constants.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
package bcd_seven_seg_scanner_pkg;

  typedef enum logic [1:0] {
    DIG0   = 2'd0,
    BLANK0 = 2'd1,
    DIG1   = 2'd2,
    BLANK1 = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render as a dash
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_DASH,   SEG_DASH,
    SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
  };

endpackage
`default_nettype wire

// File: rtl/bcd_seven_seg_scanner_digit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : bcd_digit_to_seg
// Brief   : Combinational nibble to active-low 7-segment pattern decoder.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module bcd_digit_to_seg
  import bcd_seven_seg_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  assign seg_n = (digit > 4'd9) ? SEG_DASH : SEG_TABLE[digit];

endmodule
`default_nettype wire

// File: rtl/bcd_seven_seg_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : bcd_seven_seg_scanner
// Brief   : Two-digit multiplexed common-anode display driver with blanking
//           gaps between digit slots and dash/error flag for non-BCD nibbles.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module bcd_seven_seg_scanner
  import bcd_seven_seg_scanner_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_in,
  input  logic       bcd_vld,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       bcd_err
);

  localparam int unsigned        CNT_W  = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0]   c_last = CNT_W'(REFRESH_DIV - 1);

  logic [7:0]       r_held;
  logic             r_err;
  scan_state_t      r_state;
  scan_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [6:0]       r_seg_n;
  logic [6:0]       w_seg_next;
  logic [1:0]       r_an_n;
  logic [1:0]       w_an_next;
  logic [3:0]       w_digit;
  logic [6:0]       w_digit_seg;

  // Single shared decoder; the tens nibble is selected only in its slot
  assign w_digit = (r_state == DIG1) ? r_held[7:4] : r_held[3:0];

  bcd_digit_to_seg u_dec (
    .digit (w_digit),
    .seg_n (w_digit_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_held  <= 8'h00;
      r_err   <= 1'b0;
      r_state <= DIG0;
      r_cnt   <= '0;
      r_seg_n <= SEG_BLANK;
      r_an_n  <= 2'b11;
    end else begin
      if (bcd_vld) begin
        r_held <= bcd_in;
        r_err  <= (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
      end
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_seg_n <= w_seg_next;
      r_an_n  <= w_an_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_seg_next   = SEG_BLANK;
    w_an_next    = 2'b11;
    case (r_state)
      DIG0: begin
        w_seg_next = w_digit_seg;
        w_an_next  = 2'b10;
        if (r_cnt == c_last) begin
          w_state_next = BLANK0;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      BLANK0: w_state_next = DIG1;
      DIG1: begin
        // A dash-valued tens nibble is never zero, so it is never suppressed
        if (!((BLANK_LZ != 0) && (r_held[7:4] == 4'd0))) begin
          w_seg_next = w_digit_seg;
          w_an_next  = 2'b01;
        end
        if (r_cnt == c_last) begin
          w_state_next = BLANK1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      BLANK1: w_state_next = DIG0;
      default: begin
        w_state_next = DIG0;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign seg_n   = r_seg_n;
  assign an_n    = r_an_n;
  assign bcd_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seven_seg_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_bcd_seven_seg_scanner
// Brief   : Scoreboard bench for the display scanner, LZ-blank and no-blank.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_bcd_seven_seg_scanner;

  localparam int DIV    = 4;
  localparam int PERIOD = 2 * (DIV + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bcd_in;
  logic       bcd_vld;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       err_a, err_b;

  typedef struct packed {
    logic [6:0] seg_a;
    logic [1:0] an_a;
    logic [6:0] seg_b;
    logic [1:0] an_b;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_vld(bcd_vld),
    .seg_n(seg_a), .an_n(an_a), .bcd_err(err_a)
  );

  bcd_seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(0)) dut_nlz (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_vld(bcd_vld),
    .seg_n(seg_b), .an_n(an_b), .bcd_err(err_b)
  );

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: position in the scan follows from edges since reset
  int         m_k    = 0;
  logic [7:0] m_held = 8'h00;
  logic       m_err  = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int   pos;
    e = '{seg_a: 7'h7F, an_a: 2'b11, seg_b: 7'h7F, an_b: 2'b11, err: 1'b0};
    if (!rst_n) begin
      m_k = 0; m_held = 8'h00; m_err = 1'b0;
    end else begin
      m_k++;
      pos = (m_k - 1) % PERIOD;
      if (pos < DIV) begin
        e.seg_a = pattern(m_held[3:0]); e.an_a = 2'b10;
        e.seg_b = pattern(m_held[3:0]); e.an_b = 2'b10;
      end else if (pos > DIV && pos < PERIOD - 1) begin
        e.seg_b = pattern(m_held[7:4]); e.an_b = 2'b01;
        if (m_held[7:4] != 4'd0) begin
          e.seg_a = pattern(m_held[7:4]); e.an_a = 2'b01;
        end
      end
      if (bcd_vld) begin
        m_held = bcd_in;
        m_err  = (bcd_in[7:4] > 9) || (bcd_in[3:0] > 9);
      end
      e.err = m_err;
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      check("seg_n_lz",  {1'b0, seg_a}, {1'b0, e.seg_a});
      check("an_n_lz",   {6'd0, an_a},  {6'd0, e.an_a});
      check("seg_n_nlz", {1'b0, seg_b}, {1'b0, e.seg_b});
      check("an_n_nlz",  {6'd0, an_b},  {6'd0, e.an_b});
      check("bcd_err_lz",  {7'd0, err_a}, {7'd0, e.err});
      check("bcd_err_nlz", {7'd0, err_b}, {7'd0, e.err});
      check("an_n_not_both_low", {7'd0, (an_a == 2'b00) || (an_b == 2'b00)}, 8'd0);
    end
  end

  task automatic strobe(input logic [7:0] v, input int hold);
    @(negedge clk); bcd_in = v; bcd_vld = 1'b1;
    @(negedge clk); bcd_vld = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; bcd_in = 8'h00; bcd_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    strobe(8'h09, 20);
    strobe(8'h05, 20);
    strobe(8'h1C, 20);
    strobe(8'h07, 20);
    // back-to-back strobes keep the last value
    @(negedge clk); bcd_in = 8'h42; bcd_vld = 1'b1;
    @(negedge clk); bcd_in = 8'h37;
    @(negedge clk); bcd_vld = 1'b0;
    repeat (12) @(negedge clk);
    // reset lands inside the tens slot while holding 09
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    strobe(8'h09, 5);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bcd_vld = ($urandom_range(0, 5) == 0);
      bcd_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) bcd_in[7:4] = 4'd0;
      rst_n   = ($urandom_range(0, 249) != 0);
    end
    @(negedge clk); rst_n = 1'b1; bcd_vld = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
